// File: rtl/ook_tx_pkg.sv
// Shared state encoding, counter-width helper and parameter legality check
// for the OOK frame transmitter.
package ook_tx_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYM  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_IFG  = 2'd3;

  // Bits needed for a counter running 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int payload_w, input int preamble_w,
                                   input int sym_len, input int toggle_div,
                                   input int gap_len, input int ifg_len);
    return (payload_w >= 1) && (preamble_w >= 1) && (sym_len >= 2) &&
           (toggle_div >= 1) && (gap_len >= 0) && (ifg_len >= 0);
  endfunction

endpackage

// File: rtl/ook_frame_transmitter_burst.sv
// Square-wave burst generator: starts high on restart and inverts every
// TOGGLE_DIV enabled cycles.
module ook_burst_gen
  import ook_tx_pkg::*;
#(
  parameter int TOGGLE_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic wave
);

  localparam int PH_W = cnt_w(TOGGLE_DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(TOGGLE_DIV - 1);

  logic [PH_W-1:0] ph_q, ph_d, ph_cur;
  logic            tog_q, tog_d, tog_cur;

  // restart overrides the stored phase in the same cycle, so the first
  // symbol cycle is already high without a pipeline bubble.
  always_comb begin
    tog_cur = restart ? 1'b1 : tog_q;
    ph_cur  = restart ? '0 : ph_q;
    ph_d    = ph_q;
    tog_d   = tog_q;
    if (en) begin
      if (ph_cur == PH_LAST) begin
        ph_d  = '0;
        tog_d = ~tog_cur;
      end else begin
        ph_d  = ph_cur + PH_W'(1);
        tog_d = tog_cur;
      end
    end
  end

  assign wave = tog_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q  <= '0;
      tog_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      tog_q <= tog_d;
    end
  end

endmodule

// File: rtl/ook_frame_transmitter.sv
// On-off-keyed frame transmitter: serialises {PREAMBLE, payload} MSB first as
// burst/silence symbols with gaps, optional repeats and inter-frame gaps.
module ook_frame_transmitter
  import ook_tx_pkg::*;
#(
  parameter int                    PAYLOAD_W  = 32,
  parameter int                    PREAMBLE_W = 8,
  parameter logic [PREAMBLE_W-1:0] PREAMBLE   = 8'b1011_0001,
  parameter int                    SYM_LEN    = 32,
  parameter int                    TOGGLE_DIV = 1,
  parameter int                    GAP_LEN    = 8,
  parameter int                    IFG_LEN    = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mmcm_locked,
  input  logic                 start,
  input  logic                 stop,
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic [7:0]           repeat_cnt,
  output logic                 sig_out,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [7:0]           frame_cnt
);

  localparam int FRAME_W = PREAMBLE_W + PAYLOAD_W;
  localparam int SYM_W   = cnt_w(SYM_LEN);
  localparam int GAP_W   = cnt_w(GAP_LEN);
  localparam int IFG_W   = cnt_w(IFG_LEN);
  localparam int CNT_W   = (SYM_W > GAP_W) ? ((SYM_W > IFG_W) ? SYM_W : IFG_W)
                                           : ((GAP_W > IFG_W) ? GAP_W : IFG_W);
  localparam int BIT_W   = cnt_w(FRAME_W);

  localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(SYM_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'((IFG_LEN > 0) ? IFG_LEN - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  generate
    if (!params_ok(PAYLOAD_W, PREAMBLE_W, SYM_LEN, TOGGLE_DIV, GAP_LEN, IFG_LEN)) begin : g_bad_params
      $error("ook_frame_transmitter: illegal parameter combination");
    end
  endgenerate

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bits_q, bits_d;
  logic [FRAME_W-1:0] shift_q, shift_d, frame_q, frame_d;
  logic [7:0]         budget_q, budget_d, fcnt_q, fcnt_d;
  logic               stop_pend_q, stop_pend_d;
  logic               sig_q, sig_d, done_q, done_d, aborted_q, aborted_d;
  logic               sym_end, wave;

  ook_burst_gen #(.TOGGLE_DIV(TOGGLE_DIV)) u_burst (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart ((state_q == ST_SYM) && (cnt_q == '0)),
    .en      (state_q == ST_SYM),
    .wave    (wave)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bits_d      = bits_q;
    shift_d     = shift_q;
    frame_d     = frame_q;
    budget_d    = budget_q;
    fcnt_d      = fcnt_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    sym_end     = 1'b0;
    sig_d       = (state_q == ST_SYM) && shift_q[FRAME_W-1] && wave;
    if (state_q != ST_IDLE) stop_pend_d = stop_pend_q | stop;

    case (state_q)
      ST_IDLE: begin
        if (start && mmcm_locked) begin
          state_d     = ST_SYM;
          cnt_d       = '0;
          bits_d      = BIT_LAST;
          shift_d     = {PREAMBLE, payload};
          frame_d     = {PREAMBLE, payload};
          budget_d    = repeat_cnt;
          fcnt_d      = 8'd0;
          stop_pend_d = 1'b0;
        end
      end
      ST_SYM: begin
        if (cnt_q == SYM_LAST) begin
          cnt_d = '0;
          if (GAP_LEN > 0) state_d = ST_GAP;
          else             sym_end = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          sym_end = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (cnt_q == IFG_LAST) begin
          cnt_d   = '0;
          state_d = ST_SYM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    if (sym_end) begin
      if (bits_q != '0) begin
        shift_d = shift_q << 1;
        bits_d  = bits_q - BIT_W'(1);
        state_d = ST_SYM;
      end else begin
        // Frame boundary: a budget of 0 means run until stop.
        fcnt_d = fcnt_q + 8'd1;
        if (budget_q != 8'd0) budget_d = budget_q - 8'd1;
        if ((budget_q == 8'd1) || stop_pend_q || stop) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          shift_d = frame_q;
          bits_d  = BIT_LAST;
          state_d = (IFG_LEN > 0) ? ST_IFG : ST_SYM;
        end
      end
    end

    if ((state_q != ST_IDLE) && !mmcm_locked) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      fcnt_d    = fcnt_q;
      sig_d     = 1'b0;
      done_d    = 1'b0;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bits_q      <= '0;
      shift_q     <= '0;
      frame_q     <= '0;
      budget_q    <= 8'd0;
      fcnt_q      <= 8'd0;
      stop_pend_q <= 1'b0;
      sig_q       <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      shift_q     <= shift_d;
      frame_q     <= frame_d;
      budget_q    <= budget_d;
      fcnt_q      <= fcnt_d;
      stop_pend_q <= stop_pend_d;
      sig_q       <= sig_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign sig_out   = sig_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: doc/ook_frame_transmitter.md
# ook_frame_transmitter

Parametrised on-off-keyed excitation transmitter. It serialises a latched preamble+payload word into timed symbols: a '1' is a square-wave burst, a '0' is silence, and each symbol is followed by a zero gap. Frames can repeat a set number of times or run continuously, with a start/busy/done handshake. It sits after the MMCM and drives the single-bit excitation line `sig_out` in the transmitter domain.

## Interface
- `PAYLOAD_W`, 32: payload bits per frame.
- `PREAMBLE_W`, 8: preamble bits per frame.
- `PREAMBLE`, 8'b1011_0001: preamble value, sent before the payload, MSB first.
- `SYM_LEN`, 32: clocks per symbol; must be at least 2.
- `TOGGLE_DIV`, 1: clocks per half-period of the burst square wave; must be at least 1.
- `GAP_LEN`, 8: zero clocks after every symbol; 0 skips the gap.
- `IFG_LEN`, 64: zero clocks between repeated frames; 0 skips it.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mmcm_locked` in 1: clock-valid qualifier. Low forces abort to IDLE.
- `start` in 1: level-sampled request, accepted only in IDLE with `mmcm_locked`=1.
- `stop` in 1: request a graceful stop after the current frame.
- `payload` in PAYLOAD_W: frame data, latched on start acceptance.
- `repeat_cnt` in 8: number of frames to send; 0 means continuous until `stop`.
- `sig_out` out 1: excitation output, registered.
- `busy` out 1: high while not IDLE.
- `done` out 1: one-cycle pulse when a run completes normally.
- `aborted` out 1: one-cycle pulse when `mmcm_locked` drops mid-run.
- `frame_cnt` out 8: frames completed in the current run; wraps modulo 256.

## Operation
- Reset values: `sig_out`=0, `busy`=0, `done`=0, `aborted`=0, `frame_cnt`=0. State is IDLE and all counters are 0.
- States:
  - IDLE → SYM on start acceptance. At that edge, load the shift register with {PREAMBLE, payload}, load the frame budget from `repeat_cnt`, and clear `frame_cnt` and the stop-pending flag.
  - SYM runs SYM_LEN cycles on the current MSB, then goes to GAP (or directly to the next step if GAP_LEN=0).
  - GAP runs GAP_LEN cycles, then shifts left and goes to the next SYM if bits remain.
  - At the end of a frame, increment `frame_cnt`. Go to IDLE if the budget is exhausted or stop is pending. Otherwise go to IFG (or SYM if IFG_LEN=0) and reload the shift register from the latched copy.
  - IFG runs IFG_LEN cycles, then goes to SYM.
- Burst waveform: during SYM with bit=1, the output starts at 1 on the first symbol cycle and inverts every TOGGLE_DIV cycles, restarting phase at each symbol. During SYM with bit=0, and during GAP, IFG and IDLE, the output is 0.
- `stop` is sampled in any non-IDLE state and sets a sticky stop-pending flag. The current frame always completes.
- `start` while busy is ignored. `payload` and `repeat_cnt` changes while busy have no effect.
- If `mmcm_locked` is 0 in any non-IDLE state: go to IDLE at the next edge, pulse `aborted`, do not pulse `done`, and drive `sig_out` to 0 at that same edge.
- Frame budget counter width is 8. A budget of 0 never decrements.

## Timing
- Cycle n means the cycle following rising edge n.
- Start is accepted at edge 0, so `busy`=1 from cycle 0.
- `sig_out` lags internal state by exactly one cycle. Output sample k of the run appears in cycle k+1.
- Single-frame length: F = (PREAMBLE_W+PAYLOAD_W)·(SYM_LEN+GAP_LEN) cycles.
- For a run of R frames, the state returns to IDLE at edge T = R·F + (R−1)·IFG_LEN.
  - `busy` is high in cycles 0..T−1.
  - `done` is high in cycle T only.
  - The last `sig_out` sample appears in cycle T.
- Start asserted in cycle T (already IDLE) is accepted at edge T+1. There are no dead cycles.
- `stop` arriving in the final cycle of a frame takes effect at that frame's end.

## Structure
- Package `ook_tx_pkg`:
  - state enum {IDLE, SYM, GAP, IFG};
  - `clog2`-based width localparams for the symbol, gap and IFG counters;
  - the parameter legality checks.
- Sub-module `ook_burst_gen`: the TOGGLE_DIV phase counter and toggle flip-flop, with `restart` and `en` inputs and a `wave` output.
- The top level holds the FSM, the shift register, the frame budget counter and the output registers.

## Test plan
- PREAMBLE_W=2, PREAMBLE=2'b10, PAYLOAD_W=4, payload=4'b1001, SYM_LEN=4, GAP_LEN=2, TOGGLE_DIV=1, repeat_cnt=1 → `sig_out` over cycles 1..36 is 1010 00, 0000 00, 1010 00, 0000 00, 0000 00, 1010 00. `done` is high in cycle 36 only and `busy` is high in cycles 0..35.
- Same configuration with repeat_cnt=3, IFG_LEN=3 → T=114, 3 identical frames separated by 3 zeros, `frame_cnt`=3 at done.
- repeat_cnt=0 with `stop` pulsed mid-second-frame → the second frame completes, `done` fires, `frame_cnt`=2.
- `mmcm_locked` dropped at cycle 10 → `aborted` high in cycle 11, `sig_out`=0 and `busy`=0 from cycle 11, no `done`.
- TOGGLE_DIV=2, SYM_LEN=8, bit 1 → symbol waveform 11001100. Start held during a run, and `payload` changed mid-run → neither has any effect.
- Reset asserted asynchronously mid-symbol → all outputs are 0 immediately. The first start after reset is accepted normally.
